// File: rtl/alarm_delay_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm delay scheduler slice:
//   - scheduler state enum
//   - requester indices into the {siren, entry, exit} vectors
//   - default delay presets in 10 ms ticks
//   - preset range helper used by the elaboration-time check
// -----------------------------------------------------------------------------
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int NUM_REQ   = 3;
   localparam int REQ_EXIT  = 0;
   localparam int REQ_ENTRY = 1;
   localparam int REQ_SIREN = 2;

   localparam int DEF_EXIT_TICKS  = 3000;   // 30 s
   localparam int DEF_ENTRY_TICKS = 1500;   // 15 s
   localparam int DEF_SIREN_TICKS = 18000;  // 3 min

   // A preset must be at least one tick and fit in the remaining counter.
   function automatic bit preset_ok(input int ticks, input int tickw);
      return (ticks >= 1) && (longint'(ticks) < (longint'(1) << tickw));
   endfunction

endpackage

// File: rtl/alarm_delay_scheduler_if.sv
// -----------------------------------------------------------------------------
// alarm_delay_scheduler_if
// Bundles the requester-side and timer-side signals of the scheduler.
//   master : alarm FSM / timer environment (drives requests, cancel, tick)
//   slave  : the scheduler (drives timer controls, grant, busy, done, remaining)
// -----------------------------------------------------------------------------
interface alarm_delay_scheduler_if #(
   parameter int LOADW = 10,
   parameter int TICKW = 16
);
   logic             tick;
   logic             req_exit;
   logic             req_entry;
   logic             req_siren;
   logic             cancel;
   logic             timer_en;
   logic             timer_load_en;
   logic [LOADW-1:0] timer_load_value;
   logic             timer_clr;
   logic [2:0]       grant;
   logic             busy;
   logic [2:0]       done;
   logic [TICKW-1:0] remaining;

   modport master (
      output tick, req_exit, req_entry, req_siren, cancel,
      input  timer_en, timer_load_en, timer_load_value, timer_clr,
      input  grant, busy, done, remaining
   );

   modport slave (
      input  tick, req_exit, req_entry, req_siren, cancel,
      output timer_en, timer_load_en, timer_load_value, timer_clr,
      output grant, busy, done, remaining
   );

endinterface

// File: rtl/alarm_req_arbiter.sv
// -----------------------------------------------------------------------------
// alarm_req_arbiter
// Combinational fixed-priority select, siren > entry > exit.
//   req_vec : arbiter input {siren, entry, exit} (pending | same-cycle request)
//   owner   : one-hot current grant (0 when nothing is granted)
//   win     : one-hot highest-priority requester in req_vec
//   preempt : some requester in req_vec outranks the current owner
// -----------------------------------------------------------------------------
module alarm_req_arbiter
   import alarm_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_vec,
   input  logic [NUM_REQ-1:0] owner,
   output logic [NUM_REQ-1:0] win,
   output logic               preempt
);

   logic [NUM_REQ-1:0] above_mask;

   always_comb begin
      win = '0;
      if (req_vec[REQ_SIREN]) begin
         win[REQ_SIREN] = 1'b1;
      end else if (req_vec[REQ_ENTRY]) begin
         win[REQ_ENTRY] = 1'b1;
      end else if (req_vec[REQ_EXIT]) begin
         win[REQ_EXIT] = 1'b1;
      end
   end

   // Requesters strictly above the owner; a siren owner can never be displaced.
   always_comb begin
      above_mask = '0;
      if (owner[REQ_EXIT]) begin
         above_mask[REQ_ENTRY] = 1'b1;
         above_mask[REQ_SIREN] = 1'b1;
      end else if (owner[REQ_ENTRY]) begin
         above_mask[REQ_SIREN] = 1'b1;
      end
   end

   assign preempt = |(req_vec & above_mask);

endmodule

// File: rtl/alarm_delay_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_delay_scheduler
// Shares one 10 ms timer between exit delay, entry delay and siren duration.
// Arbitrates request pulses by fixed priority (siren > entry > exit), loads
// and clears the timer for the winner, counts tick edges against the winner's
// preset and pulses a per-function done on expiry.
//   clock50 : 50 MHz system clock
//   Mr      : asynchronous active-low master reset
//   bus     : slave side of alarm_delay_scheduler_if
//             in : tick, req_exit, req_entry, req_siren, cancel
//             out: timer_en, timer_load_en, timer_load_value, timer_clr,
//                  grant[2:0], busy, done[2:0], remaining[TICKW-1:0]
// -----------------------------------------------------------------------------
module alarm_delay_scheduler
   import alarm_pkg::*;
#(
   parameter int LOADW       = 10,
   parameter int TICKW       = 16,
   parameter int LOAD_VALUE  = 0,
   parameter int EXIT_TICKS  = DEF_EXIT_TICKS,
   parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
   parameter int SIREN_TICKS = DEF_SIREN_TICKS
) (
   input  logic                   clock50,
   input  logic                   Mr,
   alarm_delay_scheduler_if.slave bus
);

   if (!preset_ok(EXIT_TICKS, TICKW) || !preset_ok(ENTRY_TICKS, TICKW) ||
       !preset_ok(SIREN_TICKS, TICKW)) begin : g_bad_preset
      $error("alarm_delay_scheduler: presets must be >= 1 and < 2**TICKW");
   end

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [TICKW-1:0]   remaining_q, remaining_d;
   logic               busy_q, busy_d;
   logic               timer_en_q, timer_en_d;
   logic               load_en_q, load_en_d;
   logic               clr_q, clr_d;
   logic               tick_q, tick_d;

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] arb_in;
   logic [NUM_REQ-1:0] win;
   logic [NUM_REQ-1:0] take;
   logic               preempt;
   logic               tick_edge;

   function automatic logic [TICKW-1:0] preset_of(input logic [NUM_REQ-1:0] sel);
      logic [TICKW-1:0] p;
      p = '0;
      if (sel[REQ_SIREN]) begin
         p = TICKW'(SIREN_TICKS);
      end else if (sel[REQ_ENTRY]) begin
         p = TICKW'(ENTRY_TICKS);
      end else if (sel[REQ_EXIT]) begin
         p = TICKW'(EXIT_TICKS);
      end
      return p;
   endfunction

   assign req_vec   = {bus.req_siren, bus.req_entry, bus.req_exit};
   assign arb_in    = pending_q | req_vec;
   assign tick_edge = bus.tick & ~tick_q;
   assign tick_d    = bus.tick;

   alarm_req_arbiter u_arb (
      .req_vec (arb_in),
      .owner   (grant_q),
      .win     (win),
      .preempt (preempt)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      done_d      = '0;
      remaining_d = remaining_q;
      timer_en_d  = 1'b0;
      load_en_d   = 1'b0;
      clr_d       = 1'b0;
      take        = '0;

      case (state_q)
         ST_IDLE: begin
            if (|arb_in) begin
               grant_d     = win;
               take        = win;
               remaining_d = preset_of(win);
               load_en_d   = 1'b1;
               clr_d       = 1'b1;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            timer_en_d = 1'b1;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            timer_en_d = 1'b1;
            if (preempt) begin
               // Displaced owner is simply dropped: no done, not re-queued.
               grant_d     = win;
               take        = win;
               remaining_d = preset_of(win);
               timer_en_d  = 1'b0;
               load_en_d   = 1'b1;
               clr_d       = 1'b1;
               state_d     = ST_LOAD;
            end else if (tick_edge) begin
               remaining_d = remaining_q - TICKW'(1);
               if (remaining_q == TICKW'(1)) begin
                  done_d     = grant_q;
                  timer_en_d = 1'b0;
                  state_d    = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      // The request that wins a grant is consumed by it, whether it came from
      // the pending register or arrived in this very cycle.
      pending_d = arb_in & ~take;

      // cancel overrides everything, including a final tick in the same cycle.
      if (bus.cancel) begin
         state_d     = ST_IDLE;
         grant_d     = '0;
         done_d      = '0;
         remaining_d = '0;
         timer_en_d  = 1'b0;
         load_en_d   = 1'b0;
         clr_d       = 1'b0;
         pending_d   = '0;
      end

      busy_d = |grant_d;
   end

   always_ff @(posedge clock50 or negedge Mr) begin
      if (!Mr) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         pending_q   <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         timer_en_q  <= 1'b0;
         load_en_q   <= 1'b0;
         clr_q       <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         pending_q   <= pending_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         timer_en_q  <= timer_en_d;
         load_en_q   <= load_en_d;
         clr_q       <= clr_d;
         tick_q      <= tick_d;
      end
   end

   assign bus.timer_en         = timer_en_q;
   assign bus.timer_load_en    = load_en_q;
   assign bus.timer_load_value = LOADW'(LOAD_VALUE);
   assign bus.timer_clr        = clr_q;
   assign bus.grant            = grant_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.remaining        = remaining_q;

endmodule

// File: tb/tb_alarm_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_delay_scheduler
// Directed bench for alarm_delay_scheduler with presets exit=5, entry=3,
// siren=4 and tick pulses one clock wide every ten clocks.
// -----------------------------------------------------------------------------
module tb_alarm_delay_scheduler;

   logic clk = 1'b0;
   logic mr_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   alarm_delay_scheduler_if #(.LOADW(10), .TICKW(16)) bus ();

   alarm_delay_scheduler #(
      .LOADW       (10),
      .TICKW       (16),
      .LOAD_VALUE  (0),
      .EXIT_TICKS  (5),
      .ENTRY_TICKS (3),
      .SIREN_TICKS (4)
   ) dut (
      .clock50 (clk),
      .Mr      (mr_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; observe 1 time unit after the edge. Pulse inputs drop.
   task automatic step();
      @(posedge clk);
      #1;
      bus.req_exit  = 1'b0;
      bus.req_entry = 1'b0;
      bus.req_siren = 1'b0;
      bus.cancel    = 1'b0;
   endtask

   // Nine quiet clocks then one clock with tick high; returns just after the
   // edge that samples the tick pulse.
   task automatic tick_period();
      repeat (9) step();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_done"}, 32'(bus.done), 32'h0);
      chk({tag, "_rem"}, 32'(bus.remaining), 32'h0);
      chk({tag, "_ten"}, 32'(bus.timer_en), 32'h0);
      chk({tag, "_lden"}, 32'(bus.timer_load_en), 32'h0);
      chk({tag, "_clr"}, 32'(bus.timer_clr), 32'h0);
   endtask

   // Observe n clocks; grant and done must stay at zero throughout.
   task automatic quiet_window(input string tag, input int n);
      logic [2:0] g_seen;
      logic [2:0] d_seen;
      g_seen = '0;
      d_seen = '0;
      for (int i = 0; i < n; i++) begin
         step();
         g_seen |= bus.grant;
         d_seen |= bus.done;
      end
      chk({tag, "_grant_seen"}, 32'(g_seen), 32'h0);
      chk({tag, "_done_seen"}, 32'(d_seen), 32'h0);
   endtask

   initial begin
      bus.tick      = 1'b0;
      bus.req_exit  = 1'b0;
      bus.req_entry = 1'b0;
      bus.req_siren = 1'b0;
      bus.cancel    = 1'b0;
      mr_n          = 1'b1;
      #2 mr_n = 1'b0;
      #1;
      chk_all_zero("reset");
      chk("reset_ldval", 32'(bus.timer_load_value), 32'h0);
      repeat (2) @(posedge clk);
      #1 mr_n = 1'b1;
      step();
      step();
      chk_all_zero("idle");

      // ---- single exit request ----
      bus.req_exit = 1'b1;
      step();
      chk("ex_grant", 32'(bus.grant), 32'h1);
      chk("ex_busy", 32'(bus.busy), 32'h1);
      chk("ex_lden", 32'(bus.timer_load_en), 32'h1);
      chk("ex_clr", 32'(bus.timer_clr), 32'h1);
      chk("ex_ten_load", 32'(bus.timer_en), 32'h0);
      chk("ex_rem5", 32'(bus.remaining), 32'd5);
      step();
      chk("ex_ten_run", 32'(bus.timer_en), 32'h1);
      chk("ex_lden_off", 32'(bus.timer_load_en), 32'h0);
      chk("ex_clr_off", 32'(bus.timer_clr), 32'h0);
      for (int k = 4; k >= 1; k--) begin
         tick_period();
         chk($sformatf("ex_rem%0d", k), 32'(bus.remaining), 32'(k));
         chk($sformatf("ex_nodone%0d", k), 32'(bus.done), 32'h0);
      end
      tick_period();
      chk("ex_rem0", 32'(bus.remaining), 32'd0);
      chk("ex_done", 32'(bus.done), 32'h1);
      chk("ex_grant_held", 32'(bus.grant), 32'h1);
      chk("ex_ten_done", 32'(bus.timer_en), 32'h0);
      step();
      chk("ex_done_pulse", 32'(bus.done), 32'h0);
      chk("ex_grant_drop", 32'(bus.grant), 32'h0);
      chk("ex_busy_drop", 32'(bus.busy), 32'h0);
      quiet_window("ex_after", 20);

      // ---- pre-emption of exit by siren ----
      bus.req_exit = 1'b1;
      step();
      step();
      tick_period();
      tick_period();
      chk("pre_rem3", 32'(bus.remaining), 32'd3);
      bus.req_siren = 1'b1;
      step();
      chk("pre_grant", 32'(bus.grant), 32'h4);
      chk("pre_rem4", 32'(bus.remaining), 32'd4);
      chk("pre_nodone", 32'(bus.done), 32'h0);
      chk("pre_lden", 32'(bus.timer_load_en), 32'h1);
      step();
      for (int k = 3; k >= 1; k--) begin
         tick_period();
         chk($sformatf("pre_rem%0d", k), 32'(bus.remaining), 32'(k));
      end
      tick_period();
      chk("pre_siren_done", 32'(bus.done), 32'h4);
      step();
      chk("pre_grant_drop", 32'(bus.grant), 32'h0);
      quiet_window("pre_no_reserve", 30);

      // ---- simultaneous exit + entry ----
      bus.req_exit  = 1'b1;
      bus.req_entry = 1'b1;
      step();
      chk("sim_grant_entry", 32'(bus.grant), 32'h2);
      chk("sim_rem3", 32'(bus.remaining), 32'd3);
      step();
      repeat (3) tick_period();
      chk("sim_entry_done", 32'(bus.done), 32'h2);
      step();
      chk("sim_idle_gap", 32'(bus.grant), 32'h0);
      step();
      chk("sim_grant_exit", 32'(bus.grant), 32'h1);
      chk("sim_rem5", 32'(bus.remaining), 32'd5);
      step();
      repeat (4) tick_period();
      chk("sim_exit_notyet", 32'(bus.done), 32'h0);
      tick_period();
      chk("sim_exit_done", 32'(bus.done), 32'h1);
      step();
      quiet_window("sim_after", 15);

      // ---- cancel on the final tick edge ----
      bus.req_entry = 1'b1;
      step();
      step();
      bus.req_exit = 1'b1;
      step();
      chk("can_keep_entry", 32'(bus.grant), 32'h2);
      tick_period();
      tick_period();
      chk("can_rem1", 32'(bus.remaining), 32'd1);
      repeat (9) step();
      bus.tick   = 1'b1;
      bus.cancel = 1'b1;
      step();
      bus.tick = 1'b0;
      chk_all_zero("can");
      quiet_window("can_pending_cleared", 15);
      bus.req_exit = 1'b1;
      step();
      chk("can_new_grant", 32'(bus.grant), 32'h1);
      chk("can_new_rem", 32'(bus.remaining), 32'd5);
      step();
      repeat (5) tick_period();
      chk("can_new_done", 32'(bus.done), 32'h1);
      step();

      // ---- held tick level ----
      bus.req_siren = 1'b1;
      step();
      step();
      bus.tick = 1'b1;
      repeat (30) step();
      bus.tick = 1'b0;
      chk("held_rem3", 32'(bus.remaining), 32'd3);
      chk("held_busy", 32'(bus.busy), 32'h1);
      repeat (3) tick_period();
      chk("held_done", 32'(bus.done), 32'h4);
      step();

      // ---- Mr asserted mid-RUN ----
      bus.req_exit = 1'b1;
      step();
      step();
      tick_period();
      tick_period();
      chk("mr_rem3", 32'(bus.remaining), 32'd3);
      mr_n = 1'b0;
      #1;
      chk_all_zero("mr_async");
      repeat (2) @(posedge clk);
      #1 mr_n = 1'b1;
      begin
         logic [2:0] d_seen;
         logic [2:0] g_seen;
         d_seen = '0;
         g_seen = '0;
         for (int i = 0; i < 7; i++) begin
            tick_period();
            d_seen |= bus.done;
            g_seen |= bus.grant;
         end
         chk("mr_no_done", 32'(d_seen), 32'h0);
         chk("mr_no_grant", 32'(g_seen), 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_delay_scheduler.md
# alarm_delay_scheduler

Shares the single 10 ms timer (ten-bit prescaler pair plus terminal-count latch) between the three timed functions of the alarm controller: exit delay, entry delay and siren duration. It arbitrates pulsed requests by fixed priority and loads, clears and enables the timer. It counts elapsed 10 ms periods against a per-function preset and pulses a per-function done. It sits between the alarm FSM (the requester) and the timer instance.

## Interface
- LOADW, 10, width of the timer load value
- TICKW, 16, width of the delay counter in 10 ms units
- LOAD_VALUE, 0, value driven on timer_load_value
- EXIT_TICKS, 3000, exit delay in ticks (30 s)
- ENTRY_TICKS, 1500, entry delay in ticks (15 s)
- SIREN_TICKS, 18000, siren duration in ticks (3 min)

- clock50  in  1  50 MHz system clock
- Mr  in  1  master reset, asynchronous, active-low
- tick  in  1  timer terminal count (level); each rising edge marks one elapsed 10 ms period
- req_exit, req_entry, req_siren  in  1 each  single-cycle request pulses
- cancel  in  1  abort the active and all pending requests (disarm)
- timer_en  out  1  timer count enable
- timer_load_en  out  1  timer load strobe
- timer_load_value  out  LOADW  constant LOAD_VALUE
- timer_clr  out  1  one-cycle timer restart/latch clear
- grant  out  3  one-hot {siren, entry, exit}; active owner
- busy  out  1  high while any grant is held
- done  out  3  one-cycle completion pulse, same bit order as grant
- remaining  out  TICKW  ticks left in the active delay

## Operation
- Each req pulse sets a pending bit. Set beats clear on the same bit in the same cycle. cancel clears all pending bits, including those set in the same cycle.
- Priority: siren > entry > exit. The arbiter input is pending | req (same-cycle visibility).
- States: IDLE, LOAD, RUN, DONE.
- IDLE: all timer outputs are 0. If there is any arbiter input, register the grant for the winner, clear its pending bit, set remaining to its preset, then go to LOAD.
- LOAD: assert timer_load_en and timer_clr for one cycle, then go to RUN. Tick edges in this state are ignored.
- RUN: timer_en=1. A tick edge (tick & ~tick_q) decrements remaining. When remaining goes 1→0, go to DONE.
- Pre-emption in RUN: if a higher-priority arbiter input appears, drop the current owner (no done, not re-queued), grant the new winner, reload remaining, then go to LOAD. Equal or lower priority inputs stay pending.
- DONE: pulse the done bit of the owner, clear grant, then go to IDLE. Pending requests are served starting from the next IDLE cycle.
- cancel in any state: next state IDLE, grant=0, remaining=0, no done. cancel beats a final tick edge in the same cycle.
- Presets must be ≥1 and < 2^TICKW. Enforce this with an elaboration-time check.

## Timing
- Reset values: state IDLE, all outputs 0, pending 0, tick_q 0.
- Request pulse at cycle N: grant and busy at N+1 (LOAD), timer_en at N+2.
- Final tick edge at cycle M: remaining=0 and state DONE at M+1. done pulses at M+1; grant and busy drop at M+2.
- Delay from grant to done equals preset × tick period, within one tick period of uncertainty (free-running prescaler phase is cleared by timer_clr).
- All outputs are registered except timer_load_value (constant).
- Mr assertion mid-delay returns everything to reset values immediately; no done is issued.

## Structure
- Package alarm_pkg holds:
  - the state enum
  - requester indices (EXIT=0, ENTRY=1, SIREN=2)
  - default preset constants
- One sub-module, alarm_req_arbiter: combinational fixed-priority one-hot select over 3 bits, plus a "higher than current owner" compare used for pre-emption.

## Test plan
Bench parameters: EXIT_TICKS=5, ENTRY_TICKS=3, SIREN_TICKS=4; tick driven as a 1-cycle pulse every 10 clocks.
- Reset: Mr low mid-RUN → all outputs 0 the same cycle; after release, no spurious done.
- Single exit request: req_exit at N → grant=001 at N+1, timer_load_en/timer_clr at N+1, done=001 exactly one cycle after the 5th tick edge; remaining counts 5,4,3,2,1,0.
- Pre-emption: exit running with remaining=3, req_siren → grant=100, remaining=4, no exit done. Siren done follows after 4 ticks; exit is not re-served.
- Simultaneous: req_exit and req_entry in the same cycle → entry is served first (done=010 after 3 ticks); exit is then served from the pending bit (done=001 after 5 more ticks).
- cancel on the same cycle as the final tick edge → no done, IDLE next cycle, pending cleared; a later req_exit is served normally.
- Held tick level: tick held high for 30 clocks → a single decrement only.
